blockade_vram_arb: RTL

BLOCKADE_VRAM_ARB -- requirements
Module: blockade_vram_arb

---
 rtl/blockade_vram_arb.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/blockade_vram_arb.sv
// Single-port VRAM arbiter: one-deep video read request queue with
// priority over a level-handshaked CPU port; all VRAM controls registered.
module blockade_vram_arb #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic          vid_overrun,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VID_RD,
        S_VID_DATA,
        S_CPU_RD,
        S_CPU_DATA,
        S_CPU_WR
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_vid_pend;
    logic [AW-1:0] r_vid_addr;
    logic          r_vid_overrun;
    logic [DW-1:0] r_vid_data;
    logic          r_vid_valid;
    logic [DW-1:0] r_cpu_dout;
    logic          r_cpu_ack;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [DW-1:0] r_ram_din;

    logic          w_vid_grant;
    logic          w_pend_d;
    logic [AW-1:0] w_vaddr_d;
    logic          w_ovr_d;
    logic [AW-1:0] w_ram_addr_d;
    logic          w_ram_we_d;
    logic [DW-1:0] w_ram_din_d;
    logic [DW-1:0] w_vid_data_d;
    logic          w_vid_valid_d;
    logic [DW-1:0] w_cpu_dout_d;
    logic          w_cpu_ack_d;

    assign w_vid_grant = (r_state == S_IDLE) && (r_vid_pend || vid_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // CPU grant is held off during the ack cycle so a requester that
    // drops cpu_req on ack is never served a second time.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (r_vid_pend || vid_req) begin
                    w_next = S_VID_RD;
                end else if (cpu_req && !r_cpu_ack) begin
                    w_next = cpu_we ? S_CPU_WR : S_CPU_RD;
                end
            end
            S_VID_RD:   w_next = S_VID_DATA;
            S_VID_DATA: w_next = S_IDLE;
            S_CPU_RD:   w_next = S_CPU_DATA;
            S_CPU_DATA: w_next = S_IDLE;
            S_CPU_WR:   w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pend_d  = r_vid_pend && !w_vid_grant;
        w_vaddr_d = r_vid_addr;
        w_ovr_d   = r_vid_overrun;
        if (vid_req) begin
            if (r_vid_pend && !w_vid_grant) begin
                w_ovr_d = 1'b1;
            end else if (r_vid_pend || !w_vid_grant) begin
                w_pend_d  = 1'b1;
                w_vaddr_d = vid_addr;
            end
        end
    end

    // VRAM controls are loaded on the edge entering each access state.
    always_comb begin
        w_ram_addr_d  = r_ram_addr;
        w_ram_we_d    = 1'b0;
        w_ram_din_d   = r_ram_din;
        w_vid_data_d  = r_vid_data;
        w_vid_valid_d = 1'b0;
        w_cpu_dout_d  = r_cpu_dout;
        w_cpu_ack_d   = 1'b0;
        unique case (w_next)
            S_VID_RD: w_ram_addr_d = r_vid_pend ? r_vid_addr : vid_addr;
            S_CPU_RD: w_ram_addr_d = cpu_addr;
            S_CPU_WR: begin
                w_ram_addr_d = cpu_addr;
                w_ram_din_d  = cpu_din;
                w_ram_we_d   = 1'b1;
            end
            default: ;
        endcase
        unique case (r_state)
            S_VID_DATA: begin
                w_vid_data_d  = ram_dout;
                w_vid_valid_d = 1'b1;
            end
            S_CPU_DATA: begin
                w_cpu_dout_d = ram_dout;
                w_cpu_ack_d  = 1'b1;
            end
            S_CPU_WR: w_cpu_ack_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vid_pend    <= 1'b0;
            r_vid_addr    <= '0;
            r_vid_overrun <= 1'b0;
            r_vid_data    <= '0;
            r_vid_valid   <= 1'b0;
            r_cpu_dout    <= '0;
            r_cpu_ack     <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_we      <= 1'b0;
            r_ram_din     <= '0;
        end else begin
            r_vid_pend    <= w_pend_d;
            r_vid_addr    <= w_vaddr_d;
            r_vid_overrun <= w_ovr_d;
            r_vid_data    <= w_vid_data_d;
            r_vid_valid   <= w_vid_valid_d;
            r_cpu_dout    <= w_cpu_dout_d;
            r_cpu_ack     <= w_cpu_ack_d;
            r_ram_addr    <= w_ram_addr_d;
            r_ram_we      <= w_ram_we_d;
            r_ram_din     <= w_ram_din_d;
        end
    end

    assign vid_data    = r_vid_data;
    assign vid_valid   = r_vid_valid;
    assign vid_overrun = r_vid_overrun;
    assign cpu_dout    = r_cpu_dout;
    assign cpu_ack     = r_cpu_ack;
    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_din     = r_ram_din;

endmodule
